// File: rtl/attack_score_controller.sv
`default_nettype none
// ============================================================================
// Module      : attack_score_controller
// Description : Battleship game controller. Maps the mode switches onto a
//               four-state game FSM, turns debounced confirm presses into a
//               one-cycle attack strobe, tracks the remaining shots and ship
//               cells, and declares win or lose.
// Revision    : 1.0 - initial release
// ============================================================================
module attack_score_controller #(
  parameter int MAX_SHOTS = 15,
  parameter int SHOT_W    = 4,
  parameter int CELL_W    = 6
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [1:0]        state_req_i,
  input  logic              confirm_i,
  input  logic [2:0]        x_coord_i,
  input  logic [2:0]        y_coord_i,
  input  logic              cell_is_ship_i,
  input  logic              cell_already_hit_i,
  input  logic [CELL_W-1:0] ship_cells_i,
  output logic [1:0]        game_state_code_o,
  output logic              attack_strobe_o,
  output logic [SHOT_W-1:0] shots_left_o,
  output logic [CELL_W-1:0] ships_left_o,
  output logic [1:0]        last_result_o,
  output logic              win_o
);

  // The state encoding doubles as the external game_state_code.
  typedef enum logic [1:0] {
    S_OFF    = 2'b00,
    S_PREP   = 2'b01,
    S_ATTACK = 2'b10,
    S_OVER   = 2'b11
  } state_t;

  localparam logic [1:0] REQ_OFF    = 2'b00;
  localparam logic [1:0] REQ_PREP   = 2'b01;
  localparam logic [1:0] REQ_ATTACK = 2'b10;

  localparam logic [1:0] RES_NONE   = 2'b00;
  localparam logic [1:0] RES_MISS   = 2'b01;
  localparam logic [1:0] RES_HIT    = 2'b10;
  localparam logic [1:0] RES_REJECT = 2'b11;

  localparam logic [SHOT_W-1:0] SHOTS_LOAD = SHOT_W'(MAX_SHOTS);
  localparam logic [SHOT_W-1:0] SHOT_ONE   = SHOT_W'(1);
  localparam logic [CELL_W-1:0] CELL_ONE   = CELL_W'(1);

  state_t              state_q, state_d;
  logic                conf_q;
  logic                strobe_q, strobe_d;
  logic [SHOT_W-1:0]   shots_q, shots_d;
  logic [CELL_W-1:0]   ships_q, ships_d;
  logic [1:0]          result_q, result_d;
  logic                win_q, win_d;

  logic                press_edge;
  logic                press_counted;
  logic                shot_invalid;

  assign press_edge   = confirm_i & ~conf_q;
  assign shot_invalid = (x_coord_i > 3'd6) || (y_coord_i > 3'd4) || cell_already_hit_i;
  // A press only counts while the game stays in ATTACK this cycle; an exit
  // (switch change or game end) takes precedence over a simultaneous shot.
  assign press_counted = press_edge && (state_q == S_ATTACK) && (state_d == S_ATTACK);

  // State and datapath registers, asynchronously cleared.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_OFF;
      conf_q   <= 1'b0;
      strobe_q <= 1'b0;
      shots_q  <= '0;
      ships_q  <= '0;
      result_q <= RES_NONE;
      win_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      conf_q   <= confirm_i;
      strobe_q <= strobe_d;
      shots_q  <= shots_d;
      ships_q  <= ships_d;
      result_q <= result_d;
      win_q    <= win_d;
    end
  end

  // Next-state selection in fixed priority; request 11 never moves the FSM.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_OFF: begin
        if (state_req_i == REQ_PREP)        state_d = S_PREP;
        else if (state_req_i == REQ_ATTACK) state_d = S_ATTACK;
      end
      S_PREP: begin
        if (state_req_i == REQ_ATTACK)      state_d = S_ATTACK;
        else if (state_req_i == REQ_OFF)    state_d = S_OFF;
      end
      S_ATTACK: begin
        if (state_req_i == REQ_OFF)         state_d = S_OFF;
        else if (state_req_i == REQ_PREP)   state_d = S_PREP;
        else if ((ships_q == '0) || (shots_q == '0)) state_d = S_OVER;
      end
      S_OVER: begin
        if (state_req_i == REQ_OFF)         state_d = S_OFF;
      end
      default: state_d = S_OFF;
    endcase
  end

  // Counter, result, win and strobe updates driven by state entry or a counted shot.
  always_comb begin
    shots_d  = shots_q;
    ships_d  = ships_q;
    result_d = result_q;
    win_d    = win_q;
    strobe_d = 1'b0;
    if (state_d != state_q) begin
      case (state_d)
        S_ATTACK: begin
          shots_d  = SHOTS_LOAD;
          ships_d  = ship_cells_i;
          result_d = RES_NONE;
          win_d    = 1'b0;
        end
        S_OVER: begin
          // Ships checked first, so sinking the last ship on the last shot wins.
          win_d = (ships_q == '0);
        end
        default: begin
          shots_d  = '0;
          ships_d  = '0;
          result_d = RES_NONE;
          win_d    = 1'b0;
        end
      endcase
    end else if (press_counted) begin
      if (shot_invalid) begin
        result_d = RES_REJECT;
      end else begin
        strobe_d = 1'b1;
        if (shots_q != '0) shots_d = shots_q - SHOT_ONE;
        if (cell_is_ship_i) begin
          if (ships_q != '0) ships_d = ships_q - CELL_ONE;
          result_d = RES_HIT;
        end else begin
          result_d = RES_MISS;
        end
      end
    end
  end

  assign game_state_code_o = state_q;
  assign attack_strobe_o   = strobe_q;
  assign shots_left_o      = shots_q;
  assign ships_left_o      = ships_q;
  assign last_result_o     = result_q;
  assign win_o             = win_q;

endmodule
`default_nettype wire
